// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word reads to instruction memory, holds the
// returned word for decode, and handles branch redirects (including redirects
// that arrive while a read is still outstanding).
//
// Optional feature: define FETCH_PREDECODE_EN to register an R-type predecode
// flag (opcode == 0) alongside the fetched word. Without the macro the flag is
// tied low and no predecode logic exists.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // Instruction memory read port
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // Decode-facing outputs
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [5:0]  if_opcode,
  output logic [31:0] if_pc,
  // Redirect
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_is_rtype
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;
  localparam logic [1:0] StFlush = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q;
  logic [31:0] ipc_q;
  logic        load;
  logic [31:0] target;

  // Target is always word-aligned; the low bits are intentionally dropped.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];
  assign target = {branch_target[31:2], 2'b00};

  // Next-state, pc and valid decisions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        // Single quiet cycle after reset; any ack arriving here is stale.
        state_d = StFetch;
        if (branch_taken) pc_d = target;
      end
      StFetch: begin
        if (imem_ack) begin
          if (branch_taken) begin
            // Returned word belongs to the wrong path: drop it, refetch.
            pc_d = target;
          end else begin
            load    = 1'b1;
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b1;
            state_d = StFull;
          end
        end else if (branch_taken) begin
          // Read still in flight at the old address; wait it out in flush.
          pc_d    = target;
          state_d = StFlush;
        end
      end
      StFull: begin
        if (branch_taken) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = StFetch;
        end else if (id_ready) begin
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      StFlush: begin
        if (branch_taken) pc_d = target;
        if (imem_ack) state_d = StFetch;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  // Registered request outputs; address only moves when a new fetch begins,
  // so it stays stable through an outstanding read (including flush).
  always_comb begin
    req_d  = (state_d == StFetch) || (state_d == StFlush);
    addr_d = (state_d == StFetch) ? pc_d : addr_q;
  end

  // Control state, pc and memory request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // Instruction and its fetch address, captured on an accepted ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
    end else if (load) begin
      instr_q <= imem_rdata;
      ipc_q   <= pc_q;
    end
  end

`ifdef FETCH_PREDECODE_EN
  logic rtype_q;

  // Predecode flag tracks the held word and drops whenever valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtype_q <= 1'b0;
    end else if (load) begin
      rtype_q <= (imem_rdata[31:26] == 6'b000000);
    end else if (!valid_d) begin
      rtype_q <= 1'b0;
    end
  end

  assign if_is_rtype = rtype_q;
`else
  assign if_is_rtype = 1'b0;
`endif

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;
  assign if_opcode = instr_q[31:26];

  // An unacknowledged request must hold its address.
  a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

  // A held instruction and an outstanding read never coexist.
  a_valid_no_req : assert property (@(posedge clk) disable iff (!rst_n)
    if_valid |-> !imem_req);

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset (word-aligned).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  read address, valid while imem_req=1.
REQ-006 imem_ack  input  1  memory completes the read this cycle; imem_rdata valid.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 if_valid  output  1  if_instr/if_pc/if_opcode hold a valid instruction.
REQ-009 id_ready  input  1  decode stage accepts the instruction this cycle.
REQ-010 if_instr  output  32  fetched instruction register.
REQ-011 if_opcode  output  6  equals if_instr[31:26]; feeds the control unit opcode input.
REQ-012 if_pc  output  32  address the if_instr word was fetched from.
REQ-013 branch_taken  input  1  redirect request, one-cycle pulse.
REQ-014 branch_target  input  32  redirect address; bits [1:0] ignored and forced to 0.
REQ-015 if_is_rtype  output  1  predecode flag (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, FULL, FLUSH.
REQ-017 IDLE: outputs quiet for exactly one cycle after reset release, then -> FETCH.
REQ-018 FETCH: imem_req=1, imem_addr=pc; imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-019 FETCH with imem_ack and no branch_taken: if_instr<=imem_rdata, if_pc<=pc, pc<=pc+4, -> FULL; if_valid=1 from the next cycle (one-cycle latency from ack).
REQ-020 FULL: if_valid=1, imem_req=0; if_instr/if_pc SHALL hold until id_ready=1; on id_ready -> FETCH, if_valid=0 next cycle.
REQ-021 pc SHALL be a 32-bit modulo counter; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-022 branch_taken in IDLE or FULL: pc<={branch_target[31:2],2'b00}, if_valid cleared next cycle, -> FETCH; branch overrides id_ready.
REQ-023 branch_taken in FETCH without imem_ack: pc<=target, -> FLUSH; request stays asserted at old address.
REQ-024 branch_taken in FETCH with imem_ack: returned word discarded, pc<=target, -> FETCH.
REQ-025 FLUSH: imem_req=1 at old address; on imem_ack data discarded, -> FETCH at target; branch_taken in FLUSH only updates pc.
REQ-026 if_valid SHALL never be 1 for a discarded word or with stale if_instr.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_is_rtype=0.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; a late imem_ack after reset release in IDLE SHALL be ignored.

Configuration
REQ-029 Macro FETCH_PREDECODE_EN: when defined, if_is_rtype SHALL be registered with if_instr as (imem_rdata[31:26]==6'b000000) and cleared with if_valid.
REQ-030 Without FETCH_PREDECODE_EN, if_is_rtype SHALL be constant 0 and no predecode logic is instantiated.

Verification
REQ-031 Reset release, imem_ack 2 cycles after each req, id_ready=1 -> imem_addr 0,4,8; if_pc follows; if_valid pulses once per word.
REQ-032 imem_rdata=32'h0000_0020 (opcode 0), id_ready=0 for 5 cycles -> if_valid,if_instr held 5 cycles, imem_req=0; with FETCH_PREDECODE_EN if_is_rtype=1.
REQ-033 branch_taken with branch_target=32'h0000_0103 during FETCH before ack -> ack word discarded, next imem_addr=32'h0000_0100, if_valid stays 0 meanwhile.
REQ-034 RESET_PC=32'hFFFF_FFFC, two fetches -> imem_addr FFFF_FFFC then 0000_0000.
REQ-035 Assert rst_n=0 in FETCH with imem_req=1 -> imem_req, if_valid drop same cycle asynchronously; after release first imem_addr=RESET_PC.
REQ-036 branch_taken and id_ready both 1 in FULL -> branch wins: if_valid=0 next cycle, imem_addr=target.
